// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, arbiter FSM states
// and the starvation counter sizing helper.
package mem_arbiter_pkg;

   localparam int WORD_W_DEF     = 32;
   localparam int STARVE_MAX_DEF = 3;

   typedef logic [WORD_W_DEF-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } arb_state_t;

   // Never returns zero, so a STARVE_MAX of 0 still yields a legal vector.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of consecutive data grants taken while a fetch waits.
// Clear wins over increment.
module arb_starve_counter
   import mem_arbiter_pkg::*;
#(
   parameter int MAX = STARVE_MAX_DEF,
   parameter int CW  = cnt_width(MAX)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          clr,
   output logic          full,
   output logic [CW-1:0] count
);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && !full) begin
         count_reg <= count_reg + CW'(1);
      end
   end

   assign full  = (count_reg == CW'(MAX));
   assign count = count_reg;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch / data) arbiter onto one RAM port. Data wins by default,
// but a fetch starved for STARVE_MAX data grants is forced through next.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int WORD_W     = WORD_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  ramstate_t         ramstate
);

   localparam int CW = cnt_width(STARVE_MAX);

   arb_state_t    state_reg;
   arb_state_t    state_next;
   arb_state_t    arb_sel;
   logic          take;
   logic          starve_full;
   logic          starve_inc;
   logic          starve_clr;
   logic [CW-1:0] starve_cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      arb_sel = IDLE;
      if (starve_full && iREN) begin
         arb_sel = IGNT;
      end else if (dREN || dWEN) begin
         arb_sel = DGNT;
      end else if (iREN) begin
         arb_sel = IGNT;
      end
   end

   // ACCESS is checked before the abort so a master that drops its request
   // in the completing cycle still completes and hands over without a bubble.
   always_comb begin
      state_next = state_reg;
      take       = 1'b0;
      iwait      = 1'b1;
      dwait      = 1'b1;
      iload      = '0;
      dload      = '0;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      case (state_reg)
         IDLE: begin
            state_next = arb_sel;
            take       = 1'b1;
         end
         IGNT: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (ramstate == ACCESS) begin
               iwait      = 1'b0;
               iload      = ramload;
               state_next = arb_sel;
               take       = 1'b1;
            end else if (!iREN) begin
               state_next = IDLE;
            end
         end
         DGNT: begin
            ramREN   = dREN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (ramstate == ACCESS) begin
               dwait      = 1'b0;
               dload      = ramload;
               state_next = arb_sel;
               take       = 1'b1;
            end else if (!(dREN || dWEN)) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Counts grants handed to data while a fetch is waiting.
   assign starve_inc = take && (arb_sel == DGNT) && iREN;
   assign starve_clr = !iREN || (take && (arb_sel == IGNT));

   arb_starve_counter #(
      .MAX (STARVE_MAX),
      .CW  (CW)
   ) u_starve (
      .clk   (CLK),
      .rst   (RST),
      .inc   (starve_inc),
      .clr   (starve_clr),
      .full  (starve_full),
      .count (starve_cnt)
   );

endmodule
